// File: rtl/f_pc_unit_pkg.sv
// Shared definitions for the fetch-stage PC generator.
//   npc_src_e    : which source the next PC was taken from
//   RESET_PC_DEF : F_PC value after reset
//   EXC_VEC_DEF  : exception entry address
package f_pc_unit_pkg;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BR,
    SRC_J,
    SRC_JR,
    SRC_ERET,
    SRC_EXC
  } npc_src_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;

endpackage

// File: rtl/f_pc_unit_ras_stack.sv
// Return-address stack kept as a circular buffer.
//   clk, reset     : clock, asynchronous active-low reset
//   push_i, pop_i  : push wdata_i / pop top; both together replace the top
//   clear_i        : empty the stack (wins over push/pop)
//   wdata_i        : return address to push
//   top_o          : current top entry, zero when empty
//   count_o        : number of valid entries
// A push onto a full stack overwrites the oldest entry, which is exactly the
// slot after the current top in the circular buffer, so count stays at DEPTH.
module ras_stack #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             top_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (clear_i) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (push_i && pop_i && (cnt_q != '0)) begin
      // JALR $ra,$ra: pop then push lands on the same slot
      wr_en  = 1'b1;
      wr_idx = ptr_q;
    end else if (push_i) begin
      // also covers push+pop on an empty stack, where the pop is a no-op
      ptr_d  = ptr_q + 1'b1;
      wr_en  = 1'b1;
      wr_idx = ptr_q + 1'b1;
      if (cnt_q != FULL) cnt_d = cnt_q + 1'b1;
    end else if (pop_i && (cnt_q != '0)) begin
      ptr_d = ptr_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage needs no reset: count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wdata_i;
  end

  assign top_o   = (cnt_q == '0) ? '0 : mem_q[ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/f_pc_unit.sv
// Fetch-stage PC generator: owns F_PC, selects the next PC from exception,
// ERET, J/JAL, JR/JALR, taken branch or sequential fetch, tracks a return
// address stack against every JR $ra, and counts redirects and RAS misses.
//   clk, reset        : clock, asynchronous active-low reset
//   stall             : hold F_PC, freeze RAS and counters (exc/eret override)
//   d_*               : D-stage instruction PC, fields and control decode
//   exc_req/eret_req  : exception entry / return (epc is the ERET target)
//   f_pc, f_adel      : fetch PC and its misalignment flag
//   ras_top/ras_count : RAS prediction and occupancy
//   redirect_cnt      : saturating count of non-sequential PC updates
//   ras_miss_cnt      : saturating count of mispredicted/empty JR $ra
module f_pc_unit
  import f_pc_unit_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = PC_W'(RESET_PC_DEF),
  parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(EXC_VEC_DEF),
  parameter int              RAS_DEPTH = 4,
  parameter int              CNT_W     = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic [PC_W-1:0]            d_pc,
  input  logic [15:0]                d_imm16,
  input  logic [25:0]                d_index26,
  input  logic [PC_W-1:0]            d_rs_val,
  input  logic                       d_branch,
  input  logic                       d_b_cond,
  input  logic                       d_jump,
  input  logic                       d_jr,
  input  logic                       d_jr_ra,
  input  logic                       d_link,
  input  logic                       exc_req,
  input  logic                       eret_req,
  input  logic [PC_W-1:0]            epc,
  output logic [PC_W-1:0]            f_pc,
  output logic                       f_adel,
  output logic [PC_W-1:0]            ras_top,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic [CNT_W-1:0]           redirect_cnt,
  output logic [CNT_W-1:0]           ras_miss_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [PC_W-1:0]  f_pc_q, f_pc_d;
  logic [CNT_W-1:0] redir_q, redir_d;
  logic [CNT_W-1:0] miss_q, miss_d;
  logic [PC_W-1:0]  npc;
  npc_src_e         src;
  logic [PC_W-1:0]  seq_pc, br_tgt, j_tgt;
  logic             upd, miss_evt;

  assign seq_pc = f_pc_q + PC_W'(4);
  assign br_tgt = d_pc + PC_W'(4) + {{(PC_W-18){d_imm16[15]}}, d_imm16, 2'b00};
  assign j_tgt  = {d_pc[PC_W-1:28], d_index26, 2'b00};

  always_comb begin
    src = SRC_SEQ;
    npc = seq_pc;
    if (exc_req) begin
      src = SRC_EXC;
      npc = EXC_VEC;
    end else if (eret_req) begin
      src = SRC_ERET;
      npc = epc;
    end else if (d_jump) begin
      src = SRC_J;
      npc = j_tgt;
    end else if (d_jr) begin
      src = SRC_JR;
      npc = d_rs_val;
    end else if (d_branch && d_b_cond) begin
      src = SRC_BR;
      npc = br_tgt;
    end
  end

  // Exception entry/return must not be lost to a stall.
  assign upd      = ~stall | exc_req | eret_req;
  // Compared against the pre-pop top.
  assign miss_evt = ~stall & d_jr_ra & ((ras_count == '0) | (d_rs_val != ras_top));

  always_comb begin
    f_pc_d  = upd ? npc : f_pc_q;
    redir_d = (upd && (src != SRC_SEQ)) ? sat_inc(redir_q) : redir_q;
    miss_d  = miss_evt ? sat_inc(miss_q) : miss_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_pc_q  <= RESET_PC;
      redir_q <= '0;
      miss_q  <= '0;
    end else begin
      f_pc_q  <= f_pc_d;
      redir_q <= redir_d;
      miss_q  <= miss_d;
    end
  end

  ras_stack #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .reset   (reset),
    .push_i  (~stall & d_link),
    .pop_i   (~stall & d_jr_ra),
    .clear_i (exc_req | eret_req),
    .wdata_i (d_pc + PC_W'(8)),
    .top_o   (ras_top),
    .count_o (ras_count)
  );

  assign f_pc         = f_pc_q;
  assign f_adel       = |f_pc_q[1:0];
  assign redirect_cnt = redir_q;
  assign ras_miss_cnt = miss_q;

endmodule
